updown_sweep_ctrl: RTL and testbench
====================================

Name: updown_sweep_ctrl

Overview:
Controller that sequences an external 4-bit up/down counter (ports Clk, reset, UpOrDown, Count) through a programmed triangle sweep between a low and a high limit, repeated N times. It is the only driver of that counter's reset and UpOrDown and watches its Count output. Start/busy/done handshake toward the issuing logic. The counter is free-running, with no enable, so the direction is a combinational function of state and observed Count.

Parameters:
WIDTH, 4, counter width; must match the controlled counter.
SWEEP_W, 8, width of the sweep-repeat count.

Ports:
Clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
abort  in  1  cancels a running sequence.
lo_lim  in  WIDTH  low turn point; latched on start.
hi_lim  in  WIDTH  high turn point; latched on start.
num_sweeps  in  SWEEP_W  full lo->hi->lo sweeps; latched on start.
ctr_count  in  WIDTH  Count from the controlled counter.
ctr_reset  out  1  drives counter reset; counter clears to 0 synchronously.
ctr_UpOrDown  out  1  drives counter UpOrDown (1 = up).
busy  out  1  high in PRELOAD/UP/DOWN.
done  out  1  one-cycle pulse at sequence end.
cfg_err  out  1  registered; set when lo_lim >= hi_lim at start; cleared on next accepted start.
aborted  out  1  registered; set by abort; cleared on next accepted start.
sweep_cnt  out  SWEEP_W  completed sweeps; cleared on accepted start.
count_fault  out  1  see Optional Feature.

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (reset).
- States: IDLE, PRELOAD, UP, DOWN, DONE. On reset: state=IDLE, done=0, cfg_err=0, aborted=0, sweep_cnt=0, count_fault=0. ctr_reset=1 and ctr_UpOrDown=1 (both combinational in IDLE).
- IDLE: ctr_reset=1, so the counter is parked at 0.
  - With start=1, latch lo/hi/N and clear sweep_cnt/cfg_err/aborted.
  - If lo>=hi: set cfg_err and go to DONE.
  - Else if N==0: go to DONE.
  - Else go to PRELOAD.
- PRELOAD: ctr_reset=0, dir=1. When ctr_count==lo, go to UP; the counter steps to lo+1 on the same edge. If lo==0, this takes 1 cycle.
- UP: dir = (ctr_count!=hi). When ctr_count==hi, dir=0 and go to DOWN.
- DOWN: dir = 0 while ctr_count!=lo. At ctr_count==lo, sweep_cnt increments.
  - If sweep_cnt+1==N: go to DONE (dir=0).
  - Else: dir=1 and go to UP.
- DONE: ctr_reset=1, done=1 for exactly one cycle, then IDLE. The counter is 0 again after DONE.
- Latency from the start edge: busy for lo+1+2*(hi-lo)*N cycles, then done. Error or N==0 case: done on the cycle after start, with no counter motion.
- abort=1 in PRELOAD/UP/DOWN: ctr_reset=1 that cycle, set aborted, go to IDLE. No done pulse. abort is ignored in IDLE/DONE.
- start outside IDLE is ignored. Inputs lo/hi/N are don't-care after they are latched.
- Reset mid-sequence: back to IDLE next edge, counter held at 0, no done.
- Counter is modulo 2^WIDTH. Because lo<hi is enforced, no wrap occurs in a legal sequence.

Optional Feature:
COUNT_CHECK_EN.
- Defined: registers the previous ctr_count and dir in PRELOAD/UP/DOWN. If ctr_count != prev+1 (dir=1) or prev-1 (dir=0), modulo 2^WIDTH, sticky count_fault=1. count_fault is cleared by reset or an accepted start; sequencing is unaffected.
- Undefined: count_fault tied to 0 and no check logic is built.

Test Plan:
- Reset held 3 cycles -> ctr_reset=1, busy=0, done=0, sweep_cnt=0; counter Count=0.
- start with lo=2, hi=5, N=1 -> Count sequence 0,1,2,3,4,5,4,3,2; busy 9 cycles; done pulse on cycle 10; sweep_cnt=1; Count=0 after DONE.
- start with lo=0, hi=15, N=2 -> two full 0..15..0 ramps with no wrap; busy 61 cycles; sweep_cnt=2; done single pulse.
- start with lo=7, hi=7, N=3 -> cfg_err=1, done next cycle, Count stays 0. Then start with N=0 (lo=1, hi=3) -> done next cycle, cfg_err=0.
- lo=1, hi=6, N=4, abort asserted at 5th busy cycle (Count=4 in UP) -> Count=0 next edge, aborted=1, no done, busy=0. A start during busy is ignored.
- With COUNT_CHECK_EN: force ctr_count to jump 3->5 during UP -> count_fault=1 and stays set through done; next start clears it.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer for an external free-running WIDTH-bit up/down counter.
// Optional build macro COUNT_CHECK_EN adds a sticky step-consistency check (count_fault).
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               Clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo_lim,
    input  logic [WIDTH-1:0]   hi_lim,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [WIDTH-1:0]   ctr_count,
    output logic               ctr_reset,
    output logic               ctr_UpOrDown,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               aborted,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               count_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_UP      = 3'd2,
        S_DOWN    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [SWEEP_W-1:0] r_n;
    logic [SWEEP_W-1:0] r_sweep_cnt;
    logic               r_cfg_err;
    logic               r_aborted;
    logic               w_busy;
    logic               w_accept;
    logic               w_abort;
    logic               w_sweep_end;
    logic [SWEEP_W-1:0] w_sweep_inc;

    assign w_busy      = (r_state == S_PRELOAD) || (r_state == S_UP) || (r_state == S_DOWN);
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_abort     = w_busy && abort;
    assign w_sweep_inc = r_sweep_cnt + 1'b1;
    assign w_sweep_end = (r_state == S_DOWN) && (ctr_count == r_lo) && !abort;

    // The counter has no enable, so direction must be valid every cycle it is out of reset.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_next       = r_state;
        ctr_reset    = 1'b0;
        ctr_UpOrDown = 1'b1;
        case (r_state)
            S_IDLE: begin
                ctr_reset = 1'b1;
                if (start) begin
                    if ((lo_lim >= hi_lim) || (num_sweeps == '0)) w_next = S_DONE;
                    else                                          w_next = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (ctr_count == r_lo) w_next = S_UP;
            end
            S_UP: begin
                if (ctr_count == r_hi) begin
                    ctr_UpOrDown = 1'b0;
                    w_next       = S_DOWN;
                end
            end
            S_DOWN: begin
                if (ctr_count != r_lo) begin
                    ctr_UpOrDown = 1'b0;
                end else if (w_sweep_inc == r_n) begin
                    ctr_UpOrDown = 1'b0;
                    w_next       = S_DONE;
                end else begin
                    w_next = S_UP;
                end
            end
            S_DONE: begin
                ctr_reset = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                ctr_reset = 1'b1;
                w_next    = S_IDLE;
            end
        endcase
        // Abort and controller reset both park the counter on the very next edge.
        if (w_abort) begin
            ctr_reset = 1'b1;
            w_next    = S_IDLE;
        end
        if (reset) ctr_reset = 1'b1;
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_n         <= '0;
            r_sweep_cnt <= '0;
            r_cfg_err   <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_lo        <= lo_lim;
                r_hi        <= hi_lim;
                r_n         <= num_sweeps;
                r_sweep_cnt <= '0;
                r_cfg_err   <= (lo_lim >= hi_lim);
                r_aborted   <= 1'b0;
            end
            if (w_abort)     r_aborted   <= 1'b1;
            if (w_sweep_end) r_sweep_cnt <= w_sweep_inc;
        end
    end

    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign cfg_err   = r_cfg_err;
    assign aborted   = r_aborted;
    assign sweep_cnt = r_sweep_cnt;

`ifdef COUNT_CHECK_EN
    logic [WIDTH-1:0] r_prev_count;
    logic             r_prev_dir;
    logic             r_prev_valid;
    logic             r_count_fault;
    logic [WIDTH-1:0] w_expect;

    // The previous sample is only trusted if the counter was stepping (not reset) on that edge.
    assign w_expect = r_prev_dir ? (r_prev_count + 1'b1) : (r_prev_count - 1'b1);

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_prev_count  <= '0;
            r_prev_dir    <= 1'b1;
            r_prev_valid  <= 1'b0;
            r_count_fault <= 1'b0;
        end else begin
            r_prev_count <= ctr_count;
            r_prev_dir   <= ctr_UpOrDown;
            r_prev_valid <= w_busy && !abort;
            if (w_accept)
                r_count_fault <= 1'b0;
            else if (w_busy && r_prev_valid && (ctr_count != w_expect))
                r_count_fault <= 1'b1;
        end
    end

    assign count_fault = r_count_fault;
`else
    assign count_fault = 1'b0;
`endif

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: models the external counter and predicts the whole sweep trajectory.
// Directed scenarios pin the model with literal values; a random phase stresses start/abort/reset.
module tb_updown_sweep_ctrl;

    logic       Clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] lo_lim;
    logic [3:0] hi_lim;
    logic [7:0] num_sweeps;
    logic [3:0] cnt;
    logic       ctr_reset;
    logic       ctr_UpOrDown;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic       aborted;
    logic [7:0] sweep_cnt;
    logic       count_fault;
    logic       glitch;

    updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(8)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .lo_lim       (lo_lim),
        .hi_lim       (hi_lim),
        .num_sweeps   (num_sweeps),
        .ctr_count    (cnt),
        .ctr_reset    (ctr_reset),
        .ctr_UpOrDown (ctr_UpOrDown),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .aborted      (aborted),
        .sweep_cnt    (sweep_cnt),
        .count_fault  (count_fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // The controlled counter: synchronous clear, free-running up/down; glitch forces a +2 step.
    initial cnt = 4'd0;
    always @(posedge Clk) begin
        if (ctr_reset)         cnt <= 4'd0;
        else if (glitch)       cnt <= cnt + 4'd2;
        else if (ctr_UpOrDown) cnt <= cnt + 4'd1;
        else                   cnt <= cnt - 4'd1;
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: the busy interval is a precomputed list of counter values.
    typedef struct {
        logic [3:0] cnt;
        logic       dir;
        logic [7:0] swc;
    } step_t;

    step_t plan[$];
    bit    m_valid  = 1'b0;
    bit    m_run    = 1'b0;
    bit    m_dpulse = 1'b0;
    bit    m_cfg    = 1'b0;
    bit    m_abt    = 1'b0;
    int    m_idx    = 0;
    int    m_n      = 0;
    int    m_swc    = 0;

    function automatic void add_step(input int v, input int s);
        step_t e;
        e.cnt = 4'(v);
        e.dir = 1'b0;
        e.swc = 8'(s);
        plan.push_back(e);
    endfunction

    function automatic void build_plan(input int lo, input int hi, input int n);
        plan.delete();
        for (int v = 0; v <= lo; v++) add_step(v, 0);
        for (int s = 0; s < n; s++) begin
            for (int v = lo + 1; v <= hi; v++) add_step(v, s);
            for (int v = hi - 1; v >= lo; v--) add_step(v, s);
        end
        // Direction on each cycle is simply "is the next value larger"; the last cycle heads down.
        for (int i = 0; i < plan.size(); i++)
            plan[i].dir = (i + 1 < plan.size()) && (plan[i+1].cnt > plan[i].cnt);
    endfunction

    initial begin
        forever begin
            @(posedge Clk);
            if (reset) begin
                m_valid  = 1'b1;
                m_run    = 1'b0;
                m_dpulse = 1'b0;
                m_cfg    = 1'b0;
                m_abt    = 1'b0;
                m_swc    = 0;
            end else if (m_run) begin
                if (abort) begin
                    m_swc = plan[m_idx].swc;
                    m_abt = 1'b1;
                    m_run = 1'b0;
                end else begin
                    m_idx++;
                    if (m_idx == plan.size()) begin
                        m_run    = 1'b0;
                        m_dpulse = 1'b1;
                        m_swc    = m_n;
                    end
                end
            end else if (m_dpulse) begin
                m_dpulse = 1'b0;
            end else if (start) begin
                m_cfg = (lo_lim >= hi_lim);
                m_abt = 1'b0;
                m_swc = 0;
                m_n   = num_sweeps;
                if (m_cfg || num_sweeps == 8'd0) begin
                    m_dpulse = 1'b1;
                end else begin
                    build_plan(lo_lim, hi_lim, num_sweeps);
                    m_idx = 0;
                    m_run = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge Clk) begin
        if (m_valid && chk_en) begin
            logic exp_rst;
            exp_rst = !m_run || abort || reset;
            check("busy",      busy,      m_run);
            check("done",      done,      m_dpulse);
            check("ctr_reset", ctr_reset, exp_rst);
            check("cfg_err",   cfg_err,   m_cfg);
            check("aborted",   aborted,   m_abt);
            check("count_fault", count_fault, 1'b0);
            if (m_run) begin
                check("count",     cnt,       plan[m_idx].cnt);
                check("sweep_cnt", sweep_cnt, plan[m_idx].swc);
                if (!exp_rst) check("dir", ctr_UpOrDown, plan[m_idx].dir);
            end else begin
                check("sweep_cnt_idle", sweep_cnt, 8'(m_swc));
                if (!m_dpulse) begin
                    check("count_idle", cnt, 4'd0);
                    check("dir_idle", ctr_UpOrDown, 1'b1);
                end
            end
        end
    end

    logic [3:0] seen[$];

    // Issues one start and follows the sequence until done or return to idle.
    task automatic run_seq(input int lo, input int hi, input int n, input int abort_at,
                           input int junk_at, input int glitch_val,
                           output int bc, output bit gd, output int ab_cnt);
        bit glitched;
        @(posedge Clk); #1;
        lo_lim     = 4'(lo);
        hi_lim     = 4'(hi);
        num_sweeps = 8'(n);
        start      = 1'b1;
        @(posedge Clk); #1;
        start      = 1'b0;
        lo_lim     = 4'($urandom);
        hi_lim     = 4'($urandom);
        num_sweeps = 8'($urandom);
        bc       = 0;
        gd       = 1'b0;
        ab_cnt   = -1;
        glitched = 1'b0;
        seen.delete();
        for (int c = 0; c < 1000; c++) begin
            if (done) begin
                gd = 1'b1;
                return;
            end
            if (!busy) return;
            bc++;
            seen.push_back(cnt);
            if (bc == abort_at) begin
                abort  = 1'b1;
                ab_cnt = int'(cnt);
            end
            if (bc == junk_at) begin
                start      = 1'b1;
                lo_lim     = 4'd0;
                hi_lim     = 4'd15;
                num_sweeps = 8'd9;
            end
            if (!glitched && glitch_val >= 0 && int'(cnt) == glitch_val && ctr_UpOrDown) begin
                glitch   = 1'b1;
                glitched = 1'b1;
            end
            @(posedge Clk); #1;
            abort  = 1'b0;
            start  = 1'b0;
            glitch = 1'b0;
        end
        check("seq_timeout", 32'd1, 32'd0);
    endtask

    logic [3:0] t1_exp [9];
    int  bc;
    bit  gd;
    int  ab_cnt;

    initial begin
        t1_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        glitch     = 1'b0;
        lo_lim     = 4'd0;
        hi_lim     = 4'd0;
        num_sweeps = 8'd0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ctr_reset", ctr_reset, 1'b1);
        check("rst_busy",      busy,      1'b0);
        check("rst_done",      done,      1'b0);
        check("rst_sweep_cnt", sweep_cnt, 8'd0);
        check("rst_count",     cnt,       4'd0);
        reset = 1'b0;

        // Single sweep 2..5.
        run_seq(2, 5, 1, -1, -1, -1, bc, gd, ab_cnt);
        check("t1_done",   gd, 1'b1);
        check("t1_busy",   bc, 9);
        check("t1_len",    seen.size(), 9);
        for (int i = 0; i < 9 && i < seen.size(); i++) check("t1_seq", seen[i], t1_exp[i]);
        check("t1_sweeps", sweep_cnt, 8'd1);
        @(posedge Clk); #1;
        check("t1_pulse", done, 1'b0);
        check("t1_park",  cnt,  4'd0);

        // Full-range double sweep.
        run_seq(0, 15, 2, -1, -1, -1, bc, gd, ab_cnt);
        check("t2_done",   gd, 1'b1);
        check("t2_busy",   bc, 61);
        check("t2_sweeps", sweep_cnt, 8'd2);
        @(posedge Clk); #1;
        check("t2_pulse", done, 1'b0);
        check("t2_park",  cnt,  4'd0);

        // Illegal limits, then zero sweeps.
        run_seq(7, 7, 3, -1, -1, -1, bc, gd, ab_cnt);
        check("t3_done",    gd,      1'b1);
        check("t3_busy",    bc,      0);
        check("t3_cfg_err", cfg_err, 1'b1);
        check("t3_count",   cnt,     4'd0);
        run_seq(1, 3, 0, -1, -1, -1, bc, gd, ab_cnt);
        check("t4_done",    gd,      1'b1);
        check("t4_busy",    bc,      0);
        check("t4_cfg_err", cfg_err, 1'b0);

        // Abort on the 5th busy cycle with a stray start on the 3rd.
        run_seq(1, 6, 4, 5, 3, -1, bc, gd, ab_cnt);
        check("t5_abort_cnt", ab_cnt,    4);
        check("t5_no_done",   gd,        1'b0);
        check("t5_busy",      busy,      1'b0);
        check("t5_aborted",   aborted,   1'b1);
        check("t5_park",      cnt,       4'd0);
        check("t5_sweeps",    sweep_cnt, 8'd0);

        // Random start/abort/reset traffic, all inputs randomised every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge Clk); #1;
            start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0) begin
                lo_lim = 4'($urandom_range(0, 14));
                hi_lim = 4'($urandom_range(int'(lo_lim) + 1, 15));
            end else begin
                lo_lim = 4'($urandom);
                hi_lim = 4'($urandom);
            end
            num_sweeps = 8'($urandom_range(0, 3));
            abort      = ($urandom_range(0, 79) == 0);
            reset      = ($urandom_range(0, 299) == 0);
        end
        @(posedge Clk); #1;
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        repeat (200) @(posedge Clk);

`ifdef COUNT_CHECK_EN
        // A 3->5 jump in UP sets the sticky fault; the next start clears it.
        chk_en = 1'b0;
        run_seq(1, 6, 1, -1, -1, 3, bc, gd, ab_cnt);
        check("t6_done",  gd,          1'b1);
        check("t6_fault", count_fault, 1'b1);
        run_seq(1, 3, 1, -1, -1, -1, bc, gd, ab_cnt);
        check("t6_done2",  gd,          1'b1);
        check("t6_clear",  count_fault, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
